// File: rtl/nios2_dbg_pkg.sv
// ---------------------------------------------------------------------------
// nios2_dbg_pkg
// Shared types and constants for the Nios II on-chip debug memory arbiter.
//   state_t    : arbiter FSM states
//   grant_t    : which requester was served most recently (AV or JT)
//   jtag_op_t  : contents of the single JTAG command slot
//   JDO_*      : bit positions of the address and write data inside jdo
// ---------------------------------------------------------------------------
package nios2_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AV_RD = 2'd1,
    ST_JT_RD = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_AV = 1'b0,
    GRANT_JT = 1'b1
  } grant_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } jtag_op_t;

  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_WDATA_MSB = 34;

  localparam logic [3:0] JTAG_BYTEENABLE = 4'hF;

  // True when two or more of the three JTAG strobes fire together.
  function automatic logic more_than_one(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/nios2_ocimem_jtag_cmd.sv
// ---------------------------------------------------------------------------
// nios2_ocimem_jtag_cmd
// Captures JTAG debug strobes into a single registered command slot and owns
// the auto-incrementing JTAG word address and the sticky overrun flag.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   i_take_a           : address-load strobe (loads o_addr from jdo)
//   i_take_b           : write strobe (queues a write of jdo write data)
//   i_no_action_a      : read strobe (queues a read)
//   i_jdo              : 38-bit JTAG data word
//   i_op_done          : arbiter finished the slot's RAM op (clear + increment)
//   o_op               : pending command in the slot
//   o_addr             : current JTAG word address
//   o_wdata            : captured write data
//   o_overrun          : sticky, a strobe was dropped
// ---------------------------------------------------------------------------
module nios2_ocimem_jtag_cmd
  import nios2_dbg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_take_a,
  input  logic              i_take_b,
  input  logic              i_no_action_a,
  input  logic [JDO_W-1:0]  i_jdo,
  input  logic              i_op_done,
  output jtag_op_t          o_op,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata,
  output logic              o_overrun
);

  jtag_op_t          r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_overrun;

  logic w_slot_busy;
  logic w_any_strobe;
  logic w_multi_strobe;
  logic w_unused_jdo;

  assign w_slot_busy    = (r_op != OP_NONE);
  assign w_any_strobe   = i_take_a | i_take_b | i_no_action_a;
  assign w_multi_strobe = more_than_one(i_take_a, i_take_b, i_no_action_a);
  assign w_unused_jdo   = ^{i_jdo[JDO_W-1:JDO_WDATA_MSB+1], i_jdo[JDO_WDATA_LSB-1:0]};

  // Slot and address register. Only one strobe is accepted per cycle, and
  // only while the slot is empty; anything else is dropped and latches the
  // overrun flag until reset. An address load touches no RAM, so it updates
  // the address directly and never occupies the slot. Completion of the
  // queued op clears the slot and steps the address, wrapping at the top.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= OP_NONE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (i_op_done) begin
        r_op   <= OP_NONE;
        r_addr <= r_addr + ADDR_W'(1);
      end

      if (w_any_strobe && (w_slot_busy || w_multi_strobe)) begin
        r_overrun <= 1'b1;
      end

      if (!w_slot_busy) begin
        if (i_take_b) begin
          r_op    <= OP_WRITE;
          r_wdata <= i_jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
        end else if (i_no_action_a) begin
          r_op <= OP_READ;
        end else if (i_take_a) begin
          r_addr <= i_jdo[JDO_ADDR_LSB +: ADDR_W];
        end
      end
    end
  end

  assign o_op      = r_op;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// nios2_ocimem_arbiter
// Shares the single-port OCI debug RAM between the CPU-side Avalon debug
// slave and the JTAG debug path. Avalon is stalled with waitrequest; JTAG
// read data is returned on MonDReg. Under contention the grant alternates.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   av_address/read/write/...     : Avalon debug memory slave
//   av_readdata, av_waitrequest   : Avalon response
//   take_action_ocimem_a/b,
//   take_no_action_ocimem_a, jdo  : JTAG command strobes and data
//   MonDReg                       : last JTAG read data
//   jtag_busy, jtag_overrun       : JTAG status
//   ram_*                         : OCI RAM port (read latency 1)
// ---------------------------------------------------------------------------
module nios2_ocimem_arbiter
  import nios2_dbg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  input  logic              av_debugaccess,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]  jdo,
  output logic [31:0]       MonDReg,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  // The FSM below assumes the RAM returns data exactly one cycle after the
  // address, so any other latency is rejected at elaboration.
  generate
    if (RD_LAT != 1) begin : g_bad_rd_lat
      $error("nios2_ocimem_arbiter: only RD_LAT = 1 is supported");
    end
  endgenerate

  state_t            r_state;
  state_t            w_next_state;
  grant_t            r_last_grant;
  grant_t            w_next_grant;
  logic [31:0]       r_mondreg;
  logic              w_op_done;
  jtag_op_t          w_jt_op;
  logic [ADDR_W-1:0] w_jt_addr;
  logic [31:0]       w_jt_wdata;
  logic              w_jt_pending;
  logic              w_av_req;
  logic              w_jt_wins;

  nios2_ocimem_jtag_cmd #(
    .ADDR_W (ADDR_W)
  ) u_jtag_cmd (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_take_a      (take_action_ocimem_a),
    .i_take_b      (take_action_ocimem_b),
    .i_no_action_a (take_no_action_ocimem_a),
    .i_jdo         (jdo),
    .i_op_done     (w_op_done),
    .o_op          (w_jt_op),
    .o_addr        (w_jt_addr),
    .o_wdata       (w_jt_wdata),
    .o_overrun     (jtag_overrun)
  );

  assign w_jt_pending = (w_jt_op != OP_NONE);
  assign w_av_req     = av_read | av_write;
  assign w_jt_wins    = w_jt_pending && (!w_av_req || (r_last_grant == GRANT_AV));

  // State, grant history and the JTAG read-data register. MonDReg captures
  // the RAM output during JT_RD, which is when the JTAG read address issued
  // in IDLE has come back from the RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GRANT_AV;
      r_mondreg    <= '0;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_grant;
      if (r_state == ST_JT_RD) begin
        r_mondreg <= ram_rdata;
      end
    end
  end

  // Grant decision, RAM drive and Avalon response. Everything is held at its
  // idle value while reset_n is low so that nothing reaches the RAM once
  // reset falls, even before the registers have been cleared. An Avalon
  // write completes in the IDLE cycle it is granted; with debugaccess low it
  // still completes but the RAM write is suppressed. A simultaneous Avalon
  // read and write is served as a read.
  always_comb begin
    w_next_state   = r_state;
    w_next_grant   = r_last_grant;
    w_op_done      = 1'b0;
    av_readdata    = '0;
    av_waitrequest = 1'b1;
    ram_addr       = av_address;
    ram_wren       = 1'b0;
    ram_byteenable = av_byteenable;
    ram_wdata      = av_writedata;

    if (reset_n) begin
      case (r_state)
        ST_IDLE: begin
          if (w_jt_wins) begin
            ram_addr = w_jt_addr;
            if (w_jt_op == OP_WRITE) begin
              ram_wren       = 1'b1;
              ram_byteenable = JTAG_BYTEENABLE;
              ram_wdata      = w_jt_wdata;
              w_op_done      = 1'b1;
              w_next_grant   = GRANT_JT;
            end else begin
              w_next_state = ST_JT_RD;
            end
          end else if (av_read) begin
            w_next_state = ST_AV_RD;
          end else if (av_write) begin
            ram_wren       = av_debugaccess;
            av_waitrequest = 1'b0;
            w_next_grant   = GRANT_AV;
          end
        end

        ST_AV_RD: begin
          av_readdata    = ram_rdata;
          av_waitrequest = 1'b0;
          w_next_state   = ST_IDLE;
          w_next_grant   = GRANT_AV;
        end

        ST_JT_RD: begin
          ram_addr     = w_jt_addr;
          w_op_done    = 1'b1;
          w_next_state = ST_IDLE;
          w_next_grant = GRANT_JT;
        end

        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  assign MonDReg   = r_mondreg;
  assign jtag_busy = w_jt_pending || (r_state == ST_JT_RD);

  // An Avalon master must never raise read and write together.
  assert property (@(posedge clk) disable iff (!reset_n) !(av_read && av_write));

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nios2_ocimem_arbiter
// Directed sequence with randomized addresses and data. A behavioural RAM
// sits on the DUT's RAM port; refMem holds what the RAM should contain and
// refJtagAddr where the next JTAG op should land.
// ---------------------------------------------------------------------------
module tb_nios2_ocimem_arbiter;

  logic        clock = 1'b0;
  logic        resetN;
  logic [7:0]  avAddress;
  logic        avRead;
  logic        avWrite;
  logic [31:0] avWritedata;
  logic [3:0]  avByteenable;
  logic        avDebugaccess;
  logic [31:0] avReaddata;
  logic        avWaitrequest;
  logic        takeA;
  logic        takeB;
  logic        takeNoA;
  logic [37:0] jdo;
  logic [31:0] monDReg;
  logic        jtagBusy;
  logic        jtagOverrun;
  logic [7:0]  ramAddr;
  logic        ramWren;
  logic [3:0]  ramByteenable;
  logic [31:0] ramWdata;
  logic [31:0] ramRdata;

  logic [31:0] ramMem [256];
  logic [31:0] refMem [256];
  logic        ramLoaded = 1'b0;
  int          wrenCount = 0;
  int          resetWrites = 0;
  int          testCount = 0;
  int          failCount = 0;
  logic [7:0]  refJtagAddr;

  nios2_ocimem_arbiter #(
    .ADDR_W (8),
    .RD_LAT (1)
  ) dut (
    .clk                     (clock),
    .reset_n                 (resetN),
    .av_address              (avAddress),
    .av_read                 (avRead),
    .av_write                (avWrite),
    .av_writedata            (avWritedata),
    .av_byteenable           (avByteenable),
    .av_debugaccess          (avDebugaccess),
    .av_readdata             (avReaddata),
    .av_waitrequest          (avWaitrequest),
    .take_action_ocimem_a    (takeA),
    .take_action_ocimem_b    (takeB),
    .take_no_action_ocimem_a (takeNoA),
    .jdo                     (jdo),
    .MonDReg                 (monDReg),
    .jtag_busy               (jtagBusy),
    .jtag_overrun            (jtagOverrun),
    .ram_addr                (ramAddr),
    .ram_wren                (ramWren),
    .ram_byteenable          (ramByteenable),
    .ram_wdata               (ramWdata),
    .ram_rdata               (ramRdata)
  );

  always #5 clock = ~clock;

  // Behavioural single-port RAM with byte enables and one-cycle read latency,
  // preloaded from the reference image on the first edge.
  always @(posedge clock) begin
    if (!ramLoaded) begin
      for (int i = 0; i < 256; i++) ramMem[i] <= refMem[i];
      ramLoaded <= 1'b1;
    end else if (ramWren === 1'b1) begin
      for (int b = 0; b < 4; b++) begin
        if (ramByteenable[b]) ramMem[ramAddr][8*b +: 8] <= ramWdata[8*b +: 8];
      end
    end
    ramRdata <= ramMem[ramAddr];
  end

  // Write activity monitors used by the debug-access and reset checks.
  always @(posedge clock) begin
    if (ramWren === 1'b1) wrenCount <= wrenCount + 1;
    if (ramWren === 1'b1 && resetN === 1'b0) resetWrites <= resetWrites + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) if (be[b]) mask = mask | (32'hFF << (8 * b));
    return (oldW & ~mask) | (newW & mask);
  endfunction

  function automatic logic [37:0] jdoAddr(input logic [7:0] a);
    logic [37:0] v;
    v = '0;
    v[24:17] = a;
    return v;
  endfunction

  function automatic logic [37:0] jdoData(input logic [31:0] d);
    logic [37:0] v;
    v = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One-cycle JTAG strobe pulse; returns at #1 after the capturing edge.
  task automatic applyStimulus(input logic a, input logic b, input logic na, input logic [37:0] j);
    @(posedge clock); #1;
    takeA = a; takeB = b; takeNoA = na; jdo = j;
    @(posedge clock); #1;
    takeA = 0; takeB = 0; takeNoA = 0;
  endtask

  task automatic waitJtagIdle(output int cyc);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!jtagBusy) break;
      cyc++;
    end
  endtask

  task automatic avWriteOp(input string tag, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic dbg);
    @(posedge clock); #1;
    avWrite = 1; avAddress = a; avWritedata = d; avByteenable = be; avDebugaccess = dbg;
    @(negedge clock);
    checkOutput({tag, "_waitreq"}, 32'(avWaitrequest), 32'd0);
    checkOutput({tag, "_wren"}, 32'(ramWren), 32'(dbg));
    @(posedge clock); #1;
    avWrite = 0;
    if (dbg) refMem[a] = mergeBytes(refMem[a], d, be);
  endtask

  task automatic avReadOp(input logic [7:0] a, output logic [31:0] d, output int cyc);
    @(posedge clock); #1;
    avRead = 1; avAddress = a;
    cyc = 0; d = 'x;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      cyc++;
      if (!avWaitrequest) begin
        d = avReaddata;
        break;
      end
    end
    @(posedge clock); #1;
    avRead = 0;
  endtask

  initial begin
    int          cyc;
    int          busyCycles;
    int          reads;
    int          lat;
    logic        done;
    logic [31:0] d;
    logic [31:0] rd;
    logic [7:0]  a;
    logic [7:0]  rdAddr;
    logic [7:0]  jtAddr;

    for (int i = 0; i < 256; i++) refMem[i] = $urandom;
    resetN = 0; avAddress = 0; avRead = 0; avWrite = 0; avWritedata = 0;
    avByteenable = 0; avDebugaccess = 0; takeA = 0; takeB = 0; takeNoA = 0; jdo = 0;
    refJtagAddr = 8'h00;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_waitreq", 32'(avWaitrequest), 32'd1);
    checkOutput("rst_wren", 32'(ramWren), 32'd0);
    checkOutput("rst_mondreg", monDReg, 32'd0);
    checkOutput("rst_busy", 32'(jtagBusy), 32'd0);
    checkOutput("rst_overrun", 32'(jtagOverrun), 32'd0);
    @(posedge clock); #1;
    resetN = 1;

    // JTAG address load, write, reload and read back
    applyStimulus(1, 0, 0, jdoAddr(8'h10));
    refJtagAddr = 8'h10;
    waitJtagIdle(cyc);
    checkOutput("jt_load_cycles", cyc, 0);
    applyStimulus(0, 1, 0, jdoData(32'hDEADBEEF));
    waitJtagIdle(cyc);
    checkOutput("jt_wr_cycles", cyc, 1);
    refMem[refJtagAddr] = 32'hDEADBEEF;
    refJtagAddr++;
    checkOutput("jt_wr_ram10", ramMem[8'h10], refMem[8'h10]);
    applyStimulus(1, 0, 0, jdoAddr(8'h10));
    refJtagAddr = 8'h10;
    applyStimulus(0, 0, 1, '0);
    waitJtagIdle(cyc);
    checkOutput("jt_rd_cycles", cyc, 2);
    checkOutput("jt_rd_mondreg", monDReg, refMem[8'h10]);
    refJtagAddr++;
    d = $urandom;
    applyStimulus(0, 1, 0, jdoData(d));
    waitJtagIdle(cyc);
    refMem[refJtagAddr] = d;
    checkOutput("jt_addr_after_rd", ramMem[8'h11], refMem[8'h11]);
    refJtagAddr++;

    // Avalon write with byte enables, then read back
    avWriteOp("av_wr20", 8'h20, 32'h12345678, 4'b0011, 1'b1);
    checkOutput("av_wr20_ram", ramMem[8'h20], refMem[8'h20]);
    avReadOp(8'h20, rd, cyc);
    checkOutput("av_rd20_data", rd, refMem[8'h20]);
    checkOutput("av_rd20_lat", cyc, 2);
    @(negedge clock);
    checkOutput("av_rd20_wr_onecyc", 32'(avWaitrequest), 32'd1);

    for (int k = 0; k < 3; k++) begin
      a = 8'($urandom_range(32'h30, 32'hEF));
      avWriteOp("av_wr_rand", a, $urandom, 4'($urandom), 1'b1);
      avReadOp(a, rd, cyc);
      checkOutput("av_rd_rand_data", rd, refMem[a]);
      checkOutput("av_rd_rand_lat", cyc, 2);
    end

    // Debug-access gate
    cyc = wrenCount;
    avWriteOp("av_nodbg", 8'h21, $urandom, 4'hF, 1'b0);
    @(negedge clock);
    checkOutput("av_nodbg_wrens", wrenCount - cyc, 0);
    checkOutput("av_nodbg_ram", ramMem[8'h21], refMem[8'h21]);

    // Contention: back-to-back Avalon reads with one JTAG write
    jtAddr = refJtagAddr;
    d = $urandom;
    busyCycles = 0; reads = 0; lat = 0;
    @(posedge clock); #1;
    rdAddr = 8'($urandom);
    if (rdAddr == jtAddr) rdAddr++;
    avRead = 1; avAddress = rdAddr;
    for (int c = 0; c < 14; c++) begin
      takeB = (c == 2);
      jdo = jdoData(d);
      @(negedge clock);
      lat++;
      if (jtagBusy) busyCycles++;
      done = 0;
      if (!avWaitrequest) begin
        checkOutput("cont_rdata", avReaddata, refMem[rdAddr]);
        checkOutput("cont_lat_le3", 32'(lat <= 3), 32'd1);
        reads++;
        lat = 0;
        done = 1;
      end
      @(posedge clock); #1;
      if (done) begin
        rdAddr = 8'($urandom);
        if (rdAddr == jtAddr) rdAddr++;
        avAddress = rdAddr;
      end
    end
    takeB = 0;
    avRead = 0;
    refMem[jtAddr] = d;
    refJtagAddr++;
    checkOutput("cont_jt_wait_le2", 32'(busyCycles >= 1 && busyCycles <= 2), 32'd1);
    checkOutput("cont_reads", reads, 6);
    checkOutput("cont_jt_ram", ramMem[jtAddr], refMem[jtAddr]);

    // Overrun: second read strobe during JT_RD is dropped
    checkOutput("ovr_before", 32'(jtagOverrun), 32'd0);
    a = 8'($urandom_range(32'h40, 32'h80));
    applyStimulus(1, 0, 0, jdoAddr(a));
    applyStimulus(0, 0, 1, '0);
    @(posedge clock); #1;
    takeNoA = 1;
    @(posedge clock); #1;
    takeNoA = 0;
    @(negedge clock);
    checkOutput("ovr_flag", 32'(jtagOverrun), 32'd1);
    checkOutput("ovr_busy_clear", 32'(jtagBusy), 32'd0);
    checkOutput("ovr_mondreg", monDReg, refMem[a]);
    repeat (3) @(negedge clock);
    checkOutput("ovr_sticky", 32'(jtagOverrun), 32'd1);
    checkOutput("ovr_no_second", 32'(jtagBusy), 32'd0);

    // Address wrap at the top of the RAM
    applyStimulus(1, 0, 0, jdoAddr(8'hFF));
    d = $urandom;
    applyStimulus(0, 1, 0, jdoData(d));
    waitJtagIdle(cyc);
    refMem[8'hFF] = d;
    checkOutput("wrap_ram_ff", ramMem[8'hFF], refMem[8'hFF]);
    applyStimulus(0, 0, 1, '0);
    waitJtagIdle(cyc);
    checkOutput("wrap_rd_addr0", monDReg, refMem[8'h00]);

    // Reset asserted during AV_RD
    @(posedge clock); #1;
    avRead = 1; avAddress = 8'h20;
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("rst_mid_in_avrd", 32'(avWaitrequest), 32'd0);
    #1;
    resetN = 0;
    avRead = 0;
    avWrite = 1; avAddress = 8'h22; avWritedata = $urandom; avByteenable = 4'hF; avDebugaccess = 1;
    #1;
    checkOutput("rst_mid_waitreq", 32'(avWaitrequest), 32'd1);
    checkOutput("rst_mid_wren", 32'(ramWren), 32'd0);
    checkOutput("rst_mid_mondreg", monDReg, 32'd0);
    checkOutput("rst_mid_overrun", 32'(jtagOverrun), 32'd0);
    checkOutput("rst_mid_busy", 32'(jtagBusy), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_mid_no_writes", resetWrites, 0);
    avWrite = 0; avDebugaccess = 0;
    resetN = 1;

    // Simultaneous write and read strobes: write wins, read dropped
    d = $urandom;
    applyStimulus(0, 1, 1, jdoData(d));
    waitJtagIdle(cyc);
    refMem[8'h00] = d;
    checkOutput("prio_cycles", cyc, 1);
    checkOutput("prio_ram0", ramMem[8'h00], refMem[8'h00]);
    checkOutput("prio_overrun", 32'(jtagOverrun), 32'd1);
    checkOutput("prio_mondreg", monDReg, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/nios2_ocimem_arbiter.md
Name: nios2_ocimem_arbiter

Overview:
- Shares the single-port on-chip debug memory (OCI RAM) between two requesters in the clk domain.
- Requester 1: the CPU-side Avalon debug memory slave.
- Requester 2: the JTAG debug path, which drives the sysclk-side strobes take_action_ocimem_a/b and take_no_action_ocimem_a plus the 38-bit jdo word.
- The block sequences JTAG address-load, read and write commands into the RAM, returns JTAG read data on MonDReg, and stalls Avalon via waitrequest.

Parameters:
ADDR_W, 8, OCI RAM word-address width (256 x 32-bit words)
RD_LAT, 1, RAM read latency in cycles; only the value 1 is supported, checked by elaboration assertion

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read request
av_write  in  1  Avalon write request
av_writedata  in  32  Avalon write data
av_byteenable  in  4  Avalon byte enables
av_debugaccess  in  1  Avalon write permitted only when 1
av_readdata  out  32  Avalon read data
av_waitrequest  out  1  Avalon stall
take_action_ocimem_a  in  1  JTAG address-load strobe
take_action_ocimem_b  in  1  JTAG write strobe
take_no_action_ocimem_a  in  1  JTAG read strobe
jdo  in  38  JTAG data: address in jdo[ADDR_W+16:17], write data in jdo[34:3]
MonDReg  out  32  last JTAG read data
jtag_busy  out  1  JTAG command pending or in flight
jtag_overrun  out  1  sticky: JTAG strobe arrived while busy
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_byteenable  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid 1 cycle after address

Behaviour:
- Reset values:
  - State = IDLE.
  - MonDReg = 0, jtag_addr = 0, pending = none.
  - jtag_overrun = 0, jtag_busy = 0.
  - av_waitrequest = 1, ram_wren = 0.
  - last_grant = AV.
- JTAG command capture (one registered slot, at most one strobe accepted per cycle):
  - ocimem_a loads jtag_addr from jdo and completes in 1 cycle; it needs no RAM access.
  - ocimem_b queues a write of jdo[34:3] with byteenable 4'hF.
  - no_action_ocimem_a queues a read.
  - If more than one strobe is high in a cycle, priority is b > no_action_a > a; the others are dropped and jtag_overrun is set.
  - A strobe that arrives while the slot is occupied is dropped and jtag_overrun is set; it stays set until reset.
- FSM states: IDLE, AV_RD, JT_RD.
- IDLE, grant rule: JTAG wins if a JTAG op is pending and (Avalon is idle or last_grant = AV); otherwise Avalon wins.
- IDLE, JTAG write granted: ram_wren = 1 for 1 cycle; jtag_addr increments (wraps 2^ADDR_W-1 -> 0); slot clears; last_grant = JT.
- IDLE, JTAG read granted: ram_addr = jtag_addr; go to JT_RD.
- IDLE, Avalon write granted:
  - ram_wren = av_debugaccess and av_waitrequest = 0, in the same cycle.
  - If av_debugaccess = 0 the write completes with no RAM write.
  - last_grant = AV.
- IDLE, Avalon read granted: ram_addr = av_address; go to AV_RD.
- av_waitrequest = 1 in IDLE unless an Avalon write is granted.
- AV_RD:
  - av_readdata = ram_rdata; av_waitrequest = 0 for exactly 1 cycle.
  - Return to IDLE; last_grant = AV.
  - Avalon read latency is therefore 2 cycles when uncontended.
- JT_RD:
  - MonDReg <= ram_rdata; jtag_addr increments; slot clears.
  - Return to IDLE; last_grant = JT.
- av_read and av_write both high: protocol violation; read wins; flagged by a simulation assertion.
- jtag_busy = slot occupied or state = JT_RD.
- Arbitration is alternating under contention, so neither side starves: JTAG waits at most 2 cycles, and Avalon waits at most 1 JTAG op plus its own.
- Avalon signals must be held while waitrequest = 1.
- Reset asserted mid-operation aborts any in-flight op immediately; nothing is written after reset_n falls.

Decomposition:
- Shared package nios2_dbg_pkg:
  - FSM state enum.
  - jdo field position constants (address LSB 17, write data [34:3]).
  - Grant enum {AV, JT}.
- One natural sub-module: nios2_ocimem_jtag_cmd, which holds the command slot, jtag_addr and overrun logic.
- The arbiter FSM stays in the top level.

Test Plan:
- Address-load then write and read back:
  - ocimem_a with address field 8'h10, then ocimem_b with data 32'hDEADBEEF, then ocimem_a to 8'h10, then no_action_ocimem_a.
  - Expect RAM[0x10] = DEADBEEF and MonDReg = DEADBEEF.
  - Expect jtag_addr = 0x11 after the read.
- Avalon path:
  - Write to 0x20 with data 0x12345678, byteenable 4'b0011 and debugaccess = 1: RAM low halfword is updated, waitrequest = 0 in the same cycle.
  - Read of 0x20: data valid on cycle 2, waitrequest low for exactly 1 cycle.
- Debug-access gate: Avalon write with debugaccess = 0 completes with waitrequest low, and ram_wren never asserts.
- Contention: Avalon reads held continuously while a JTAG write strobe fires; the grant order alternates, the JTAG op completes within 2 cycles, and no Avalon read returns wrong data.
- Overrun: a second no_action_ocimem_a strobe while JT_RD is in progress is dropped, jtag_overrun = 1 and stays 1, and the first read completes correctly.
- Wrap and reset: a JTAG write at 0xFF makes jtag_addr = 0x00; asserting reset_n low during AV_RD returns all outputs to their reset values within the same cycle.
